// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the data-memory responder: FSM state
//                encodings, word geometry and the address legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;
    localparam int         WORD_BYTES = 4;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT,
        S_RESP = ST_RESP
    } state_t;

    // A byte address is illegal when it is not word-aligned or when any bit
    // above the RAM's word-index field is set.
    function automatic logic addr_is_bad(input logic [31:0] addr, input int addr_w);
        logic [31:0] hi;
        hi = addr >> (addr_w + 2);
        return (addr[1:0] != 2'b00) || (hi != 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ram
//  Description : Single-port synchronous word RAM with per-byte write enables
//                and a registered read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_ram
    import mips_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [WORD_BYTES-1:0] be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int LANE_W = DATA_W / WORD_BYTES;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane writes and registered reads; the read register holds its
    // value between accesses so the responder can present it for many cycles.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < WORD_BYTES; i++) begin
                    if (be[i]) begin
                        mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                    end
                end
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Valid/ready data-memory responder. Accepts one word request,
//                stalls WAIT_CYCLES cycles, performs the RAM access and holds
//                the response until the requester takes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import mips_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [WORD_BYTES-1:0] req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                state_q,     state_d;
    logic [3:0]            cnt_q,       cnt_d;
    logic                  wr_q,        wr_d;
    logic [31:0]           addr_q,      addr_d;
    logic [DATA_W-1:0]     wdata_q,     wdata_d;
    logic [WORD_BYTES-1:0] be_q,        be_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic                  rsp_load_q,  rsp_load_d;

    logic                  access_err;
    logic                  ram_en;
    logic [DATA_W-1:0]     ram_rdata;

    assign access_err = addr_is_bad(addr_q, ADDR_W);

    // State, counter, request latch and response flags; reset aborts any
    // request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_load_q  <= rsp_load_d;
        end
    end

    // Next-state logic. RESP has two phases: the first edge in RESP performs
    // the RAM access and raises rsp_valid; afterwards the state waits for
    // rsp_ready, so rsp_ready is ignored until a response is actually shown.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_load_d  = rsp_load_q;
        req_ready   = 1'b0;
        ram_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (!rsp_valid_q) begin
                    ram_en      = !access_err;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = access_err;
                    rsp_load_d  = !wr_q && !access_err;
                end else if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_load_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    dmem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (wr_q),
        .be    (be_q),
        .addr  (addr_q[ADDR_W+1:2]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_load_q ? ram_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Two instances are
//                exercised: index 0 with two wait states, index 1 with none.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int ADDR_W = 10;
    localparam int W0     = 2;
    localparam int W1     = 0;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
    logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0][3:0]  req_be;

    int checks   = 0;
    int failures = 0;

    // Reference memory image per instance, indexed by word.
    logic [31:0] mem_m [2][1024];

    // Request to hold on the request port while a response is outstanding.
    logic        pend_en = 1'b0;
    logic        pend_wr;
    logic [31:0] pend_addr, pend_wdata;
    logic [3:0]  pend_be;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(32), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(32), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= (32'd4 << ADDR_W));
    endfunction

    function automatic int lat_of(input int d);
        return ((d == 0) ? W0 : W1) + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: accept, latency, optional back-pressure, retire.
    task automatic txn(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input int hold, input logic early);
        logic [31:0] exp_d;
        logic        exp_e;
        int          idx;
        exp_e = model_bad(addr);
        idx   = int'(addr / 4);
        exp_d = (!wr && !exp_e) ? mem_m[d][idx] : 32'd0;
        if (wr && !exp_e) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_m[d][idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        rsp_ready[d] = early;
        chk($sformatf("req_ready_idle%0d", d), 32'(req_ready[d]), 32'd1);
        step();
        if (pend_en) begin
            req_write[d] = pend_wr;
            req_addr[d]  = pend_addr;
            req_wdata[d] = pend_wdata;
            req_be[d]    = pend_be;
        end else begin
            req_valid[d] = 1'b0;
        end
        for (int k = 1; k <= lat_of(d); k++) begin
            chk($sformatf("rsp_valid_early%0d", d), 32'(rsp_valid[d]), 32'd0);
            chk($sformatf("req_ready_busy%0d", d), 32'(req_ready[d]), 32'd0);
            step();
        end
        chk($sformatf("rsp_valid_lat%0d", d), 32'(rsp_valid[d]), 32'd1);
        chk($sformatf("rsp_rdata%0d", d), rsp_rdata[d], exp_d);
        chk($sformatf("rsp_err%0d", d), 32'(rsp_err[d]), 32'(exp_e));
        if (hold > 0) begin
            rsp_ready[d] = 1'b0;
            for (int h = 0; h < hold; h++) begin
                step();
                chk($sformatf("hold_valid%0d", d), 32'(rsp_valid[d]), 32'd1);
                chk($sformatf("hold_rdata%0d", d), rsp_rdata[d], exp_d);
                chk($sformatf("hold_err%0d", d), 32'(rsp_err[d]), 32'(exp_e));
                chk($sformatf("hold_req_ready%0d", d), 32'(req_ready[d]), 32'd0);
            end
        end
        rsp_ready[d] = 1'b1;
        step();
        rsp_ready[d] = 1'b0;
        chk($sformatf("retire_valid%0d", d), 32'(rsp_valid[d]), 32'd0);
        chk($sformatf("retire_req_ready%0d", d), 32'(req_ready[d]), 32'd1);
    endtask

    // Reset asserted right after a store is accepted: no write, no response.
    task automatic abort_store(input int d, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid[d] = 1'b1;
        req_write[d] = 1'b1;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = 4'hF;
        step();
        req_valid[d] = 1'b0;
        rst = 1'b1;
        #2;
        chk($sformatf("abort_req_ready%0d", d), 32'(req_ready[d]), 32'd1);
        step();
        rst = 1'b0;
        for (int k = 0; k < lat_of(d) + 1; k++) begin
            chk($sformatf("abort_no_rsp%0d", d), 32'(rsp_valid[d]), 32'd0);
            step();
        end
    endtask

    initial begin
        logic [31:0] a, w;
        int          r;
        req_valid = '0; req_write = '0; rsp_ready = '0;
        req_addr  = '0; req_wdata = '0; req_be    = '0;
        rst = 1'b1;

        // Reset takes effect before any clock edge.
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_req_ready%0d", d), 32'(req_ready[d]), 32'd1);
            chk($sformatf("rst_rsp_valid%0d", d), 32'(rsp_valid[d]), 32'd0);
            chk($sformatf("rst_rsp_rdata%0d", d), rsp_rdata[d], 32'd0);
            chk($sformatf("rst_rsp_err%0d", d), 32'(rsp_err[d]), 32'd0);
        end
        step();
        rst = 1'b0;
        step();

        // Full-word store then load, then a single-byte merge.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
        txn(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, 0, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
        txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0);

        // Error cases: misaligned load, out-of-range store aliasing word 0.
        txn(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0, 1'b0);
        txn(0, 1'b0, 32'h13, 32'h0, 4'h0, 0, 1'b0);
        txn(0, 1'b1, 32'h1000, 32'h11111111, 4'hF, 0, 1'b0);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);

        // Back-pressure with a second request held throughout.
        pend_en = 1'b1; pend_wr = 1'b0; pend_addr = 32'h0; pend_wdata = 32'h0; pend_be = 4'h0;
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b0);
        pend_en = 1'b0;
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0);

        // Asynchronous reset mid-cycle while a load response is pending.
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10;
        step();
        req_valid[0] = 1'b0;
        repeat (lat_of(0)) step();
        chk("pre_rst_valid", 32'(rsp_valid[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("midrst_rsp_rdata", rsp_rdata[0], 32'd0);
        chk("midrst_req_ready", 32'(req_ready[0]), 32'd1);
        step();
        rst = 1'b0;
        step();

        // Reset during a store's wait phase leaves the old word intact.
        for (int d = 0; d < 2; d++) begin
            txn(d, 1'b1, 32'h20, 32'h12345678, 4'hF, 0, 1'b0);
            abort_store(d, 32'h20, 32'hCAFEF00D);
            txn(d, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);
        end

        // Randomized traffic against the reference memory image.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                txn(d, 1'b1, 32'h100 + 32'(4 * i), $urandom, 4'hF, 0, 1'b0);
            end
            for (int i = 0; i < 60; i++) begin
                r = $urandom_range(0, 99);
                if (r < 70)      a = 32'h100 + 32'(4 * $urandom_range(0, 7));
                else if (r < 85) a = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
                else             a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
                w = $urandom;
                txn(d, 1'($urandom_range(0, 1)), a, w, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
